// File: rtl/fp_accum_seq.sv
// Streaming reduction sequencer feeding a pipelined FP adder: pairs live values
// (returning adder result, held value, new input) until one sum remains.
module fp_accum_seq #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    output logic             add_ce,
    input  logic [WIDTH-1:0] add_z,
    output logic             sum_valid,
    output logic [WIDTH-1:0] sum_data,
    output logic [CNTW-1:0]  sum_count
);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic [LAT-1:0]   issue_v_q, issue_v_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [CNTW-1:0]  sum_count_q, sum_count_d;
    logic [WIDTH-1:0] sum_data_q, sum_data_d;
    logic             sum_valid_q, sum_valid_d;

    logic             ret_v;
    logic             accept;
    logic             issue;
    logic [WIDTH-1:0] op_a, op_b;

    assign ret_v     = issue_v_q[LAT-1];
    // Ready drops whenever a returning result must pair with the held value.
    assign in_ready  = rst_n && (state_q == ACCUM) && !(ret_v && hold_v_q);
    assign accept    = in_valid && in_ready;

    assign add_a     = op_a;
    assign add_b     = op_b;
    assign add_op    = 1'b0;
    assign add_ce    = rst_n;
    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;
    assign sum_count = sum_count_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        count_d     = count_q;
        sum_count_d = sum_count_q;
        sum_data_d  = sum_data_q;
        sum_valid_d = 1'b0;
        issue       = 1'b0;
        op_a        = '0;
        op_b        = '0;

        if (ret_v && hold_v_q) begin
            issue    = 1'b1;
            op_a     = add_z;
            op_b     = hold_q;
            hold_v_d = 1'b0;
        end else if (ret_v && accept) begin
            issue = 1'b1;
            op_a  = add_z;
            op_b  = in_data;
        end else if (hold_v_q && accept) begin
            issue    = 1'b1;
            op_a     = hold_q;
            op_b     = in_data;
            hold_v_d = 1'b0;
        end else if (ret_v) begin
            hold_d   = add_z;
            hold_v_d = 1'b1;
        end else if (accept) begin
            hold_d   = in_data;
            hold_v_d = 1'b1;
        end

        if (accept) begin
            count_d = count_q + CNTW'(1);
            if (in_last) begin
                state_d = DRAIN;
            end
        end

        // A lone held value with nothing in flight is the finished sum.
        if ((state_q == DRAIN) && hold_v_q && (issue_v_q == '0)) begin
            sum_data_d  = hold_q;
            sum_count_d = count_q;
            sum_valid_d = 1'b1;
            hold_v_d    = 1'b0;
            count_d     = '0;
            state_d     = ACCUM;
        end

        issue_v_d = (issue_v_q << 1) | LAT'(issue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            hold_v_q    <= 1'b0;
            issue_v_q   <= '0;
            count_q     <= '0;
            sum_count_q <= '0;
            sum_data_q  <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_v_q    <= hold_v_d;
            issue_v_q   <= issue_v_d;
            count_q     <= count_d;
            sum_count_q <= sum_count_d;
            sum_data_q  <= sum_data_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq with a behavioural two-stage FP adder and a sum scoreboard.
module tb_fp_accum_seq;
    localparam int WIDTH = 32;
    localparam int LAT   = 2;
    localparam int CNTW  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] add_a, add_b, add_z;
    logic             add_op, add_ce;
    logic             sum_valid;
    logic [WIDTH-1:0] sum_data;
    logic [CNTW-1:0]  sum_count;

    int checks = 0;
    int passes = 0;
    int pulses = 0;
    int opce_bad = 0;

    logic [WIDTH-1:0] exp_data_q[$];
    int               exp_cnt_q[$];
    logic             rlog[$];

    always #5 clk = ~clk;

    fp_accum_seq #(.WIDTH(WIDTH), .LAT(LAT), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .add_a(add_a), .add_b(add_b),
        .add_op(add_op), .add_ce(add_ce), .add_z(add_z), .sum_valid(sum_valid),
        .sum_data(sum_data), .sum_count(sum_count)
    );

    function automatic real to_real(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] to_bits(input real r);
        logic        s;
        int          e;
        real         m;
        logic [22:0] man;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        man = 23'(longint'((m - 1.0) * 8388608.0));
        return {s, 8'(e + 127), man};
    endfunction

    // Behavioural adder: operands sampled at edge k, result valid after edge k+1.
    logic [31:0] p1 = 32'd0;
    logic [31:0] p2 = 32'd0;
    always @(posedge clk) begin
        if (add_ce) begin
            p1 <= to_bits(to_real(add_a) + to_real(add_b));
            p2 <= p1;
        end
    end
    assign add_z = p2;

    always @(negedge clk) begin
        if (rst_n && (add_op !== 1'b0 || add_ce !== 1'b1)) opce_bad++;
    end

    always @(negedge clk) begin
        logic [31:0] ed;
        int          ec;
        if (rst_n === 1'b1 && sum_valid === 1'b1) begin
            pulses++;
            checks++;
            if (exp_data_q.size() == 0) begin
                $display("FAIL spurious_sum: got data=%h count=%0d, expected no pulse", sum_data, sum_count);
            end else begin
                ed = exp_data_q.pop_front();
                ec = exp_cnt_q.pop_front();
                if (sum_data !== ed || sum_count !== CNTW'(ec))
                    $display("FAIL sum_result: got data=%h count=%0d, expected data=%h count=%0d",
                             sum_data, sum_count, ed, ec);
                else passes++;
            end
        end
    end

    task automatic expect_sum(input logic [31:0] d, input int c);
        exp_data_q.push_back(d);
        exp_cnt_q.push_back(c);
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int   n;
        logic r;
        n = 0;
        r = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!r && n < 100) begin
            @(negedge clk);
            r = in_ready;
            rlog.push_back(r);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!r) begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed %b, expected 1 within 100 cycles", r);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_data_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_data_q.size() != 0)
            $display("FAIL %s_done: %0d sums outstanding, expected 0", name, exp_data_q.size());
        else passes++;
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL %s_in_ready: got %b expected 0", name, in_ready);
        else passes++;
        checks++;
        if (sum_valid !== 1'b0) $display("FAIL %s_sum_valid: got %b expected 0", name, sum_valid);
        else passes++;
        checks++;
        if (sum_data !== 32'd0) $display("FAIL %s_sum_data: got %h expected 0", name, sum_data);
        else passes++;
        checks++;
        if (sum_count !== 16'd0) $display("FAIL %s_sum_count: got %0d expected 0", name, sum_count);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_four();
        opce_bad = 0;
        expect_sum(32'h41200000, 4);
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'h40800000, 1'b1);
        wait_done("four");
        checks++;
        if (opce_bad !== 0) $display("FAIL four_op_ce: got %0d bad cycles expected 0", opce_bad);
        else passes++;
    endtask

    task automatic test_single();
        expect_sum(32'h3FC00000, 1);
        send(32'h3FC00000, 1'b1);
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0) $display("FAIL single_early: got sum_valid=%b expected 0", sum_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b1) $display("FAIL single_timing: got sum_valid=%b expected 1", sum_valid);
        else passes++;
        wait_done("single");
    endtask

    task automatic test_eight();
        logic exp_r[13] = '{1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        rlog.delete();
        expect_sum(32'h41000000, 8);
        for (int i = 0; i < 8; i++) send(32'h3F800000, (i == 7));
        checks++;
        if (rlog.size() != 13) $display("FAIL eight_ready_len: got %0d cycles expected 13", rlog.size());
        else passes++;
        for (int i = 0; i < 13; i++) begin
            if (i < rlog.size()) begin
                checks++;
                if (rlog[i] !== exp_r[i])
                    $display("FAIL eight_ready_c%0d: got %b expected %b", i, rlog[i], exp_r[i]);
                else passes++;
            end
        end
        wait_done("eight");
    endtask

    task automatic test_gapped();
        expect_sum(32'h40C00000, 3);
        for (int i = 0; i < 3; i++) begin
            send(32'h40000000, (i == 2));
            repeat (3) @(posedge clk);
            #1;
        end
        wait_done("gapped");
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
        expect_sum(32'h40000000, 2);
        expect_sum(32'h40400000, 1);
        send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b1);
        send(32'h40400000, 1'b1);
        wait_done("b2b");
        checks++;
        if (pulses - p0 !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulses - p0);
        else passes++;
    endtask

    task automatic test_mid_reset();
        int p0;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pulses;
        expect_sum(32'h40A00000, 1);
        send(32'h40A00000, 1'b1);
        wait_done("midrst");
        checks++;
        if (pulses - p0 !== 1) $display("FAIL midrst_pulses: got %0d expected 1", pulses - p0);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        test_reset();
        test_four();
        test_single();
        test_eight();
        test_gapped();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Streaming reduction sequencer placed directly upstream of the pipelined FP adder (fpadd).
- Accepts a vector of single-precision values on a valid/ready stream and issues pairwise additions to the adder.
- Recirculates the adder's results until one sum remains, then presents that sum and the element count.
- Hides the adder's fixed pipeline latency by pairing any two live values: a returning adder result, a held value, or a new input.

Parameters:
- WIDTH, 32: FP word width; matches the adder operand width.
- LAT, 2: cycles from operand sample edge to valid add_z. Operands are sampled at edge k; add_z is valid during the cycle after edge k+LAT-1.
- CNTW, 16: element counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input element valid
- in_data  in  WIDTH  input element
- in_last  in  1  marks the final element of a vector
- in_ready  out  1  element accepted on an edge when in_valid && in_ready
- add_a  out  WIDTH  adder operand A (combinational)
- add_b  out  WIDTH  adder operand B (combinational)
- add_op  out  1  adder op; constant 0 (add)
- add_ce  out  1  adder clock enable; 1 whenever rst_n is high
- add_z  in  WIDTH  adder result
- sum_valid  out  1  one-cycle pulse: sum_data and sum_count are valid
- sum_data  out  WIDTH  reduced sum; held until the next pulse
- sum_count  out  CNTW  elements in the reduced vector; wraps modulo 2^CNTW

Behaviour:
- Reset (async, rst_n=0) values:
  - in_ready=0, sum_valid=0, sum_data=0, sum_count=0.
  - state=ACCUM; hold_v=0; issue shift register all 0; element counter 0.
  - add_a and add_b are don't-care but driven 0.
- In-flight tracking:
  - issue_v[LAT-1:0] shifts each cycle. Bit 0 is set on an issue.
  - ret_v = issue_v[LAT-1] marks add_z as valid this cycle.
  - live = hold_v + ret_v + in-flight count.
- Per-cycle pairing in ACCUM, in priority order:
  - ret_v && hold_v: issue add_a=add_z, add_b=hold; hold_v<=0; in_ready=0.
  - ret_v && accepted input: issue add_a=add_z, add_b=in_data.
  - hold_v && accepted input: issue add_a=hold, add_b=in_data; hold_v<=0.
  - Exactly one live source this cycle (ret or input) with hold empty: store it in hold; hold_v<=1.
  - in_ready = (state==ACCUM) && !(ret_v && hold_v).
- A non-issue cycle shifts a 0 into issue_v. Operands never change between issue and the sample edge.
- On acceptance with in_last=1:
  - state<=DRAIN.
  - count<=count+1, latched into sum_count when the sum is delivered.
- DRAIN:
  - in_ready=0.
  - Pairing continues between ret and hold only.
  - When hold_v=1 and no issue_v bits are set: sum_data<=hold; sum_valid<=1 for one cycle.
  - On that same edge: hold_v<=0, counter<=0, state<=ACCUM.
- Single-element vector: the element is stored in hold. The sum pulse occurs in the cycle after edge k+1, where k is the accept edge.
- Zero-length vectors are not representable; in_last always accompanies a real element.
- Arithmetic:
  - No FP arithmetic is performed in this block.
  - Operand order is fixed by the rules above, so results are deterministic for a given input timing.
- Reset mid-operation:
  - Partial sums are discarded and issue_v is cleared.
  - Stale add_z values arriving after reset are ignored.
  - No sum_valid is produced for the aborted vector.
- A new vector may begin on the cycle sum_valid is asserted.

Test Plan:
- Vector {1.0, 2.0, 3.0, 4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000), in_valid held high:
  - one sum_valid pulse with sum_data=0x41200000 (10.0) and sum_count=4;
  - add_op=0 and add_ce=1 throughout.
- Single element 1.5 (0x3FC00000) with in_last, accepted at edge k:
  - sum_valid in the cycle after edge k+1, sum_data=0x3FC00000, sum_count=1;
  - no add issued.
- Eight 1.0 values streamed continuously:
  - sum_data=0x41000000, sum_count=8;
  - in_ready deasserts in every cycle where ret_v && hold_v, and never otherwise.
- Gapped input: {2.0, 2.0, 2.0} with 3 idle cycles between elements → sum_data=0x40C00000, sum_count=3.
- Back-to-back vectors {1.0, 1.0} then {3.0}:
  - two pulses, 0x40000000/2 then 0x40400000/1;
  - the second vector's values do not mix into the first sum.
- rst_n pulsed low for 1 cycle after 3 of 5 elements of a vector:
  - outputs return to reset values immediately;
  - a following vector {5.0} yields exactly one pulse, 0x40A00000 with count 1.
